l2_write_buffer: RTL and testbench

L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

---
 rtl/l2_write_buffer.sv | 176 +++++++++++++++++
 tb/tb_l2_write_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_write_buffer.sv
// Multi-channel L2 write buffer: per-channel FIFOs drained round-robin to memory, with store-to-load forwarding.
// Optional macro L2WB_COALESCE_EN merges a write into a pending entry of the same channel and address.
module l2_write_buffer #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int CH     = 2,
   parameter int DEPTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CH-1:0]        wr_valid,
   input  logic [CH*ADDR_W-1:0] wr_addr,
   input  logic [CH*DATA_W-1:0] wr_data,
   output logic [CH-1:0]        wr_ready,
   input  logic [ADDR_W-1:0]    lk_addr,
   output logic [DATA_W-1:0]    lk_data,
   output logic                 lk_hit,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_data,
   output logic                 mem_start_write,
   input  logic                 read_stop_en,
   output logic                 stop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [ADDR_W-1:0]         addr_q [CH][DEPTH];
   logic [DATA_W-1:0]         data_q [CH][DEPTH];
   logic [CH-1:0][PW-1:0]     head;
   logic [CH-1:0][PW-1:0]     tail;
   logic [CH-1:0][PW:0]       count;
   logic [0:0]                state;
   logic [CW-1:0]             rr;
   logic [CW-1:0]             sel;
   logic [CW-1:0]             rr_next;
   logic [CH-1:0]             nonempty;
   logic [CH-1:0]             push;
   logic [CH-1:0]             pop;
   logic                      any_ne;
   logic                      do_load;

   always_comb begin
      stop     = 1'b0;
      nonempty = '0;
      for (int c = 0; c < CH; c++) begin
         nonempty[c] = (count[c] != '0);
         stop        = stop | (count[c] == (PW+1)'(DEPTH));
      end
   end

   // Round-robin pick: first nonempty channel at or above rr, wrapping.
   always_comb begin
      int  idx;
      logic found;
      // NOTE: every variable gets a default first so no path can leave it unassigned (no latch).
      idx     = 0;
      found   = 1'b0;
      sel     = '0;
      any_ne  = |nonempty;
      for (int k = 0; k < CH; k++) begin
         idx = (int'(rr) + k) % CH;
         if (!found && nonempty[idx]) begin
            sel   = CW'(idx);
            found = 1'b1;
         end
      end
      rr_next = CW'((int'(sel) + 1) % CH);
      do_load = any_ne && ((state == IDLE) || !read_stop_en);
      pop     = '0;
      for (int c = 0; c < CH; c++) pop[c] = do_load && (int'(sel) == c);
   end

`ifdef L2WB_COALESCE_EN
   logic [CH-1:0]         coal;
   logic [CH-1:0][PW-1:0] coal_idx;

   // The head leaving this edge is not a merge target; such a write becomes a normal push.
   always_comb begin
      logic [PW-1:0] slot;
      slot     = '0;
      coal     = '0;
      coal_idx = '0;
      wr_ready = '0;
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot = PW'(int'(head[c]) + k);
            if (k < int'(count[c]) && !(k == 0 && pop[c]) &&
                addr_q[c][slot] == wr_addr[c*ADDR_W +: ADDR_W]) begin
               coal[c]     = 1'b1;
               coal_idx[c] = slot;
            end
         end
         wr_ready[c] = (count[c] < (PW+1)'(DEPTH)) || coal[c];
      end
   end

   assign push = wr_valid & wr_ready & ~coal;
`else
   always_comb begin
      wr_ready = '0;
      for (int c = 0; c < CH; c++) wr_ready[c] = (count[c] < (PW+1)'(DEPTH));
   end

   assign push = wr_valid & wr_ready;
`endif

   // NOTE: entry storage has no reset; validity comes solely from the reset pointers and counts.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (push[c]) begin
            addr_q[c][tail[c]] <= wr_addr[c*ADDR_W +: ADDR_W];
            data_q[c][tail[c]] <= wr_data[c*DATA_W +: DATA_W];
         end
`ifdef L2WB_COALESCE_EN
         else if (wr_valid[c] && coal[c]) begin
            data_q[c][coal_idx[c]] <= wr_data[c*DATA_W +: DATA_W];
         end
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         state           <= IDLE;
         rr              <= '0;
         mem_addr        <= '0;
         mem_data        <= '0;
         mem_start_write <= 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (push[c]) tail[c] <= tail[c] + 1'b1;
            if (pop[c])  head[c] <= head[c] + 1'b1;
            count[c] <= count[c] + {{PW{1'b0}}, push[c]} - {{PW{1'b0}}, pop[c]};
         end
         if (do_load) begin
            mem_addr        <= addr_q[sel][head[sel]];
            mem_data        <= data_q[sel][head[sel]];
            mem_start_write <= 1'b1;
            rr              <= rr_next;
            state           <= SEND;
         end else if (state == SEND && !read_stop_en) begin
            mem_start_write <= 1'b0;
            state           <= IDLE;
         end
      end
   end

   // Forwarding: later assignments override earlier ones, so the scan order encodes priority.
   always_comb begin
      logic [PW-1:0] slot;
      slot    = '0;
      lk_hit  = 1'b0;
      lk_data = '0;
      if (mem_start_write && mem_addr == lk_addr) begin
         lk_hit  = 1'b1;
         lk_data = mem_data;
      end
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot = PW'(int'(head[c]) + k);
            if (k < int'(count[c]) && addr_q[c][slot] == lk_addr) begin
               lk_hit  = 1'b1;
               lk_data = data_q[c][slot];
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed self-checking bench for l2_write_buffer (CH=2, DEPTH=8, 64-bit address/data).
module tb_l2_write_buffer;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int CH = 2;
   localparam int DEPTH = 8;

   logic            clk;
   logic            reset;
   logic [CH-1:0]   wr_valid;
   logic [CH*AW-1:0] wr_addr;
   logic [CH*DW-1:0] wr_data;
   logic [CH-1:0]   wr_ready;
   logic [AW-1:0]   lk_addr;
   logic [DW-1:0]   lk_data;
   logic            lk_hit;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_data;
   logic            mem_start_write;
   logic            read_stop_en;
   logic            stop;

   int tests = 0;
   int fails = 0;

   l2_write_buffer #(.ADDR_W(AW), .DATA_W(DW), .CH(CH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .lk_addr(lk_addr), .lk_data(lk_data), .lk_hit(lk_hit),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_start_write(mem_start_write),
      .read_stop_en(read_stop_en), .stop(stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int c, input logic [63:0] a, input logic [63:0] d);
      wr_valid[c]         = 1'b1;
      wr_addr[c*AW +: AW] = a;
      wr_data[c*DW +: DW] = d;
   endtask

   task automatic clr_wr();
      wr_valid = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] seq [6];
      reset        = 1'b0;
      wr_valid     = '0;
      wr_addr      = '0;
      wr_data      = '0;
      lk_addr      = '0;
      read_stop_en = 1'b0;

      // Reset state
      #3;
      check("reset_msw", mem_start_write, 0);
      check("reset_stop", stop, 0);
      check("reset_ready", wr_ready, 2'b11);
      check("reset_hit", lk_hit, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Single write latency
      set_wr(0, 64'h100, 64'hAA);
      tick();
      clr_wr();
      check("lat_msw_n", mem_start_write, 0);
      lk_addr = 64'h100;
      #1;
      check("lat_fifo_hit", lk_hit, 1);
      check("lat_fifo_data", lk_data, 64'hAA);
      tick();
      check("lat_msw_n1", mem_start_write, 1);
      check("lat_addr", mem_addr, 64'h100);
      check("lat_data", mem_data, 64'hAA);
      tick();
      check("lat_msw_n2", mem_start_write, 0);

      // Newest-entry forwarding and hold under read_stop_en
      read_stop_en = 1'b1;
      set_wr(0, 64'h200, 64'h11);
      tick();
      set_wr(0, 64'h200, 64'h22);
      tick();
      clr_wr();
      lk_addr = 64'h200;
      #1;
      check("fwd_hit", lk_hit, 1);
      check("fwd_newest", lk_data, 64'h22);
      lk_addr = 64'h300;
      #1;
      check("fwd_miss_hit", lk_hit, 0);
      check("fwd_miss_data", lk_data, 0);
      check("hold_data0", mem_data, 64'h11);
      tick();
      check("hold_msw", mem_start_write, 1);
      check("hold_data1", mem_data, 64'h11);
      read_stop_en = 1'b0;
      tick();
      check("fwd_drain2", mem_data, 64'h22);
      tick();
      check("fwd_idle", mem_start_write, 0);

      // Cross-channel priority, and output register below FIFO entries
      read_stop_en = 1'b1;
      set_wr(0, 64'h500, 64'h1);
      set_wr(1, 64'h500, 64'h2);
      tick();
      clr_wr();
      lk_addr = 64'h500;
      #1;
      check("xch_hi_wins", lk_data, 64'h2);
      tick();
      check("xch_rr_pick", mem_data, 64'h2);
      check("xch_reg_low", lk_data, 64'h1);
      read_stop_en = 1'b0;
      tick();
      check("xch_second", mem_data, 64'h1);
      tick();
      check("xch_idle", mem_start_write, 0);

      // Fill channel 1 while the output is held
      read_stop_en = 1'b1;
      set_wr(0, 64'h10, 64'h5);
      tick();
      clr_wr();
      for (int i = 0; i < DEPTH; i++) begin
         set_wr(1, 64'h1000 + 64'(i), 64'hD0 + 64'(i));
         tick();
      end
      clr_wr();
      check("full_stop", stop, 1);
      check("full_ready", wr_ready, 2'b01);
      check("full_held", mem_addr, 64'h10);
      set_wr(1, 64'h1FFF, 64'hEE);
      tick();
      clr_wr();
      check("full_reject", stop, 1);
      read_stop_en = 1'b0;
      tick();
      check("full_stop_fall", stop, 0);
      check("full_ready_back", wr_ready, 2'b11);
      check("full_first_addr", mem_addr, 64'h1000);
      check("full_first_data", mem_data, 64'hD0);
      for (int i = 1; i < DEPTH; i++) begin
         tick();
         check("full_order", mem_data, 64'hD0 + 64'(i));
         check("full_msw", mem_start_write, 1);
      end
      tick();
      check("full_drained", mem_start_write, 0);

      // Round-robin, back-to-back drain
      read_stop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_wr(0, 64'h2000 + 64'(i), 64'h20 + 64'(i));
         set_wr(1, 64'h3000 + 64'(i), 64'h30 + 64'(i));
         tick();
      end
      clr_wr();
      seq[0] = 64'h2000; seq[1] = 64'h3000; seq[2] = 64'h2001;
      seq[3] = 64'h3001; seq[4] = 64'h2002; seq[5] = 64'h3002;
      check("rr_first", mem_addr, seq[0]);
      read_stop_en = 1'b0;
      for (int j = 1; j < 6; j++) begin
         tick();
         check("rr_order", mem_addr, seq[j]);
         check("rr_b2b", mem_start_write, 1);
      end
      tick();
      check("rr_idle", mem_start_write, 0);

      // Same-address writes to a held channel
      read_stop_en = 1'b1;
      set_wr(1, 64'h77, 64'h9);
      tick();
      clr_wr();
      set_wr(0, 64'h40, 64'h1);
      tick();
      set_wr(0, 64'h40, 64'h2);
      tick();
      clr_wr();
      check("same_blocker", mem_addr, 64'h77);
      lk_addr = 64'h40;
      #1;
      check("same_fwd", lk_data, 64'h2);
      read_stop_en = 1'b0;
      tick();
`ifdef L2WB_COALESCE_EN
      check("coal_only", mem_data, 64'h2);
      tick();
      check("coal_single", mem_start_write, 0);
`else
      check("nocoal_first", mem_data, 64'h1);
      tick();
      check("nocoal_second", mem_data, 64'h2);
      check("nocoal_msw", mem_start_write, 1);
      tick();
      check("nocoal_done", mem_start_write, 0);
`endif

      // Reset mid-transfer with four entries pending
      read_stop_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_wr(0, 64'h4000 + 64'(i), 64'h40 + 64'(i));
         tick();
      end
      clr_wr();
      check("rst_pre_msw", mem_start_write, 1);
      check("rst_pre_addr", mem_addr, 64'h4000);
      #2 reset = 1'b0;
      #1;
      check("rst_msw", mem_start_write, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_stop", stop, 0);
      lk_addr = 64'h4001;
      #1;
      check("rst_no_hit", lk_hit, 0);
      read_stop_en = 1'b0;
      #1 reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rst_no_write", mem_start_write, 0);
      end
      check("rst_ready", wr_ready, 2'b11);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
